// File: rtl/neuro_pkg.sv
// neuro_pkg: shared command/state encodings and header-byte field positions
//   for the neurochip configuration sequencer.
package neuro_pkg;
   localparam int CMD_MSB = 7;
   localparam int CMD_LSB = 6;
   localparam int ARG_W   = 6;
   typedef enum logic [1:0] {CMD_NOP, CMD_LOAD, CMD_RUN, CMD_HALT} cmd_e;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_RUN} state_e;
endpackage

// File: rtl/neuro_step_timer.sv
// neuro_step_timer: divides the clock into evenly spaced step pulses and
//   counts issued steps against an optional limit.
//   clk_i/rst_ni   clock, synchronous active-low reset
//   ena_i          low freezes all state
//   start_i        (re)start a run with limit count_i (0 = free-run)
//   halt_i         stop the run; suppresses a step due on the same edge
//   step_o         registered step pulse (ungated)
//   done_o         high with the step that reached the limit
//   steps_done_o   steps issued in the current/last run, modulo 256
module neuro_step_timer
   import neuro_pkg::*;
#(
   parameter int STEP_DIV = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ena_i,
   input  logic             start_i,
   input  logic             halt_i,
   input  logic [ARG_W-1:0] count_i,
   output logic             step_o,
   output logic             done_o,
   output logic [7:0]       steps_done_o
);
   localparam int DW = $clog2(STEP_DIV);
   localparam logic [DW-1:0] LAST = DW'(STEP_DIV - 1);
   logic [DW-1:0]    div_q;
   logic [ARG_W-1:0] rem_q;
   logic [7:0]       steps_q, steps_d;
   logic             active_q, step_q, done_q;
   assign steps_d      = steps_q + 8'd1;
   assign step_o       = step_q;
   assign done_o       = done_q;
   assign steps_done_o = steps_q;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         div_q    <= '0;
         rem_q    <= '0;
         steps_q  <= '0;
         active_q <= 1'b0;
         step_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (ena_i) begin
         step_q <= 1'b0;
         done_q <= 1'b0;
         if (start_i) begin
            div_q    <= '0;
            rem_q    <= count_i;
            steps_q  <= '0;
            active_q <= 1'b1;
         end else if (halt_i) begin
            active_q <= 1'b0;
         end else if (active_q) begin
            div_q <= (div_q == LAST) ? '0 : div_q + 1'b1;
            if (div_q == LAST) begin
               step_q  <= 1'b1;
               steps_q <= steps_d;
               // limit reached: stop counting, the controller leaves RUN next edge
               if (rem_q != '0 && steps_d == {2'b00, rem_q}) begin
                  done_q   <= 1'b1;
                  active_q <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: rtl/neuro_cfg_sequencer.sv
// neuro_cfg_sequencer: byte-stream command controller for the neuron/weight
//   array; LOAD writes weight bytes sequentially, RUN/HALT sequence steps.
//   clk_i/rst_ni          clock, synchronous active-low reset
//   ena_i                 low freezes all state, masks cfg_ready_o and step_o
//   cfg_valid_i/cfg_data_i/cfg_ready_o  command byte handshake
//   cell_addr_o/cell_wdata_o/cell_we_o  array write port
//   step_o                single-cycle array update pulse
//   running_o/loaded_o/err_o/steps_done_o  status
module neuro_cfg_sequencer
   import neuro_pkg::*;
#(
   parameter int NUM_CELLS = 16,
   parameter int CELL_AW   = 4,
   parameter int STEP_DIV  = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               ena_i,
   input  logic               cfg_valid_i,
   input  logic [7:0]         cfg_data_i,
   output logic               cfg_ready_o,
   output logic [CELL_AW-1:0] cell_addr_o,
   output logic [7:0]         cell_wdata_o,
   output logic               cell_we_o,
   output logic               step_o,
   output logic               running_o,
   output logic               loaded_o,
   output logic               err_o,
   output logic [7:0]         steps_done_o
);
   localparam logic [ARG_W:0] NCELLS = (ARG_W + 1)'(NUM_CELLS);
   state_e             state_q;
   logic [ARG_W:0]     len_q, cnt_q, cnt_d;
   logic [CELL_AW-1:0] addr_q;
   logic [7:0]         wdata_q;
   logic               we_q, running_q, loaded_q, err_q;
   logic               xfer, in_range, t_start, t_halt, t_step, t_done;
   cmd_e               cmd;
   logic [ARG_W-1:0]   arg;
   assign cmd          = cmd_e'(cfg_data_i[CMD_MSB:CMD_LSB]);
   assign arg          = cfg_data_i[ARG_W-1:0];
   assign cfg_ready_o  = ena_i & (state_q != ST_WRITE);
   assign xfer         = cfg_valid_i & cfg_ready_o;
   assign cnt_d        = cnt_q + 1'b1;
   assign in_range     = cnt_q < NCELLS;
   assign t_start      = xfer & (state_q == ST_IDLE) & (cmd == CMD_RUN) & loaded_q;
   assign t_halt       = xfer & (state_q == ST_RUN) & (cmd == CMD_HALT);
   assign cell_addr_o  = addr_q;
   assign cell_wdata_o = wdata_q;
   assign cell_we_o    = we_q;
   assign step_o       = t_step & ena_i;
   assign running_o    = running_q;
   assign loaded_o     = loaded_q;
   assign err_o        = err_q;
   neuro_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .ena_i        (ena_i),
      .start_i      (t_start),
      .halt_i       (t_halt),
      .count_i      (arg),
      .step_o       (t_step),
      .done_o       (t_done),
      .steps_done_o (steps_done_o)
   );
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         running_q <= 1'b0;
         loaded_q  <= 1'b0;
         err_q     <= 1'b0;
      end else if (ena_i) begin
         we_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (xfer) begin
               case (cmd)
                  CMD_NOP: err_q <= 1'b0;
                  CMD_LOAD: begin
                     len_q    <= {1'b0, arg} + 1'b1;
                     cnt_q    <= '0;
                     loaded_q <= 1'b0;
                     state_q  <= ST_LOAD;
                  end
                  CMD_RUN: begin
                     running_q <= loaded_q;
                     err_q     <= err_q | ~loaded_q;
                     state_q   <= loaded_q ? ST_RUN : ST_IDLE;
                  end
                  default: ;
               endcase
            end
            ST_LOAD: if (xfer) begin
               // bytes past the array end are consumed but never written
               addr_q  <= cnt_q[CELL_AW-1:0];
               wdata_q <= cfg_data_i;
               we_q    <= in_range;
               err_q   <= err_q | ~in_range;
               state_q <= ST_WRITE;
            end
            ST_WRITE: begin
               cnt_q    <= cnt_d;
               loaded_q <= (cnt_d == len_q) & (len_q <= NCELLS);
               state_q  <= (cnt_d == len_q) ? ST_IDLE : ST_LOAD;
            end
            ST_RUN: begin
               if (xfer && cmd != CMD_HALT) err_q <= 1'b1;
               if (t_halt || t_done) begin
                  running_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_neuro_cfg_sequencer.sv
// tb_neuro_cfg_sequencer: randomized scenario bench with a behavioural model
//   of load writes, step timing and status flags.
module tb_neuro_cfg_sequencer;
   localparam int NUM = 16;
   localparam int AW  = 4;
   localparam int DIV = 4;
   logic          clk = 1'b0, rst_n = 1'b0, ena = 1'b1, cfg_valid = 1'b0;
   logic [7:0]    cfg_data = 8'h00;
   logic          cfg_ready, cell_we, step, running, loaded, err;
   logic [AW-1:0] cell_addr;
   logic [7:0]    cell_wdata, steps_done;
   int            tests = 0, fails = 0, cyc = 0;
   int            wa[$], wd[$], wc[$], sq[$];
   logic [7:0]    ld[$];
   bit            m_loaded = 0, m_err = 0;
   neuro_cfg_sequencer #(.NUM_CELLS(NUM), .CELL_AW(AW), .STEP_DIV(DIV)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .ena_i        (ena),
      .cfg_valid_i  (cfg_valid),
      .cfg_data_i   (cfg_data),
      .cfg_ready_o  (cfg_ready),
      .cell_addr_o  (cell_addr),
      .cell_wdata_o (cell_wdata),
      .cell_we_o    (cell_we),
      .step_o       (step),
      .running_o    (running),
      .loaded_o     (loaded),
      .err_o        (err),
      .steps_done_o (steps_done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (cell_we) begin
         wa.push_back(int'(cell_addr));
         wd.push_back(int'(cell_wdata));
         wc.push_back(cyc);
      end
      if (step) sq.push_back(cyc);
      if (step || cell_we) begin
         tests++;
         if (step && cell_we) begin
            fails++;
            $display("FAIL overlap cyc=%0d step=1 cell_we=1, required at most one high", cyc);
         end
      end
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end
   task automatic send(input logic [7:0] b, output int acc);
      acc = -1;
      cfg_valid = 1'b1;
      cfg_data = b;
      for (int i = 0; i < 40 && acc < 0; i++) begin
         if (cfg_ready) begin
            @(posedge clk);
            @(negedge clk);
            acc = cyc;
         end else @(negedge clk);
      end
      cfg_valid = 1'b0;
      tests++;
      if (acc < 0) begin
         fails++;
         $display("FAIL send_timeout byte=%02h never accepted", b);
      end
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({cell_we, step, running, loaded, err, steps_done, cell_addr, cell_wdata} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got we=%b step=%b run=%b ld=%b err=%b sd=%0d addr=%0d data=%02h, required all 0",
                  cell_we, step, running, loaded, err, steps_done, cell_addr, cell_wdata);
      end
      rst_n = 1'b1;
      m_loaded = 0;
      m_err = 0;
      @(negedge clk);
   endtask
   task automatic test_load();
      int a, n, len;
      int la[$];
      len = ld.size();
      n = len < NUM ? len : NUM;
      wa.delete(); wd.delete(); wc.delete();
      send({2'b01, 6'(len - 1)}, a);
      foreach (ld[i]) begin
         send(ld[i], a);
         la.push_back(a);
      end
      repeat (3) @(negedge clk);
      m_loaded = (len <= NUM);
      m_err = m_err | (len > NUM);
      tests++;
      if (wa.size() != n) begin
         fails++;
         $display("FAIL load_count len=%0d got=%0d writes, required %0d", len, wa.size(), n);
      end else for (int i = 0; i < n; i++) begin
         tests++;
         if (wa[i] != i || wd[i] != int'(ld[i]) || wc[i] != la[i]) begin
            fails++;
            $display("FAIL load_write #%0d got addr=%0d data=%02h cyc=%0d, required addr=%0d data=%02h cyc=%0d",
                     i, wa[i], wd[i], wc[i], i, ld[i], la[i]);
         end
      end
      for (int i = 1; i < len; i++) begin
         tests++;
         if (la[i] - la[i-1] != 2) begin
            fails++;
            $display("FAIL load_rate byte %0d accepted %0d cycles after previous, required 2", i, la[i] - la[i-1]);
         end
      end
      tests++;
      if (loaded !== m_loaded || err !== m_err) begin
         fails++;
         $display("FAIL load_flags got loaded=%b err=%b, required loaded=%b err=%b", loaded, err, m_loaded, m_err);
      end
   endtask
   task automatic test_run(input int n);
      int a, en;
      bit exp;
      sq.delete();
      send({2'b10, 6'(n)}, a);
      if (!m_loaded) m_err = 1;
      for (int c = 0; c <= n * DIV + 3; c++) begin
         exp = m_loaded && c <= n * DIV;
         tests++;
         if (running !== exp) begin
            fails++;
            $display("FAIL run_running +%0d got=%b required=%b", c, running, exp);
         end
         @(negedge clk);
      end
      en = m_loaded ? n : 0;
      tests++;
      if (sq.size() != en) begin
         fails++;
         $display("FAIL run_step_count got=%0d required=%0d", sq.size(), en);
      end else foreach (sq[k]) begin
         tests++;
         if (sq[k] != a + DIV * (k + 1)) begin
            fails++;
            $display("FAIL run_step_time #%0d got=+%0d required=+%0d", k, sq[k] - a, DIV * (k + 1));
         end
      end
      if (m_loaded) begin
         tests++;
         if (steps_done !== 8'(n)) begin
            fails++;
            $display("FAIL run_steps_done got=%0d required=%0d", steps_done, n);
         end
      end
      tests++;
      if (err !== m_err) begin
         fails++;
         $display("FAIL run_err got=%b required=%b", err, m_err);
      end
   endtask
   task automatic test_halt(input int h, input bit stray);
      int a, x, en;
      sq.delete();
      send(8'h80, a);
      if (stray) begin
         send(8'h41, x);
         m_err = 1;
         tests++;
         if (err !== 1'b1 || running !== 1'b1) begin
            fails++;
            $display("FAIL run_stray got err=%b running=%b, required err=1 running=1", err, running);
         end
      end
      while (cyc < a + h - 1) @(negedge clk);
      send(8'hC0, x);
      tests++;
      if (x != a + h) begin
         fails++;
         $display("FAIL halt_accept got=+%0d required=+%0d", x - a, h);
      end
      repeat (2 * DIV) @(negedge clk);
      en = (h - 1) / DIV;
      tests++;
      if (sq.size() != en) begin
         fails++;
         $display("FAIL halt_step_count h=%0d got=%0d required=%0d", h, sq.size(), en);
      end else foreach (sq[k]) begin
         tests++;
         if (sq[k] != a + DIV * (k + 1)) begin
            fails++;
            $display("FAIL halt_step_time #%0d got=+%0d required=+%0d", k, sq[k] - a, DIV * (k + 1));
         end
      end
      tests++;
      if (steps_done !== 8'(en) || running !== 1'b0 || err !== m_err) begin
         fails++;
         $display("FAIL halt_status got sd=%0d run=%b err=%b, required sd=%0d run=0 err=%b",
                  steps_done, running, err, en, m_err);
      end
   endtask
   task automatic test_nop();
      int a;
      send({2'b00, 6'($urandom)}, a);
      m_err = 0;
      tests++;
      if (err !== 1'b0) begin
         fails++;
         $display("FAIL nop_clears_err got=%b required=0", err);
      end
   endtask
   task automatic test_err_paths();
      int a;
      test_run(0);
      send(8'hC5, a);
      tests++;
      if (err !== 1'b1 || running !== 1'b0) begin
         fails++;
         $display("FAIL idle_halt_ignored got err=%b running=%b, required err=1 running=0", err, running);
      end
      test_nop();
   endtask
   task automatic test_ena_freeze();
      int a, x;
      sq.delete();
      send(8'h80, a);
      while (cyc < a + 5) @(negedge clk);
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (cfg_ready !== 1'b0 || step !== 1'b0) begin
            fails++;
            $display("FAIL ena_freeze got ready=%b step=%b, required 0 0", cfg_ready, step);
         end
      end
      ena = 1'b1;
      while (cyc < a + 15) @(negedge clk);
      send(8'hC0, x);
      repeat (DIV) @(negedge clk);
      tests++;
      if (sq.size() != 2) begin
         fails++;
         $display("FAIL ena_step_count got=%0d required=2", sq.size());
      end else begin
         tests++;
         if (sq[0] != a + 4 || sq[1] != a + 13) begin
            fails++;
            $display("FAIL ena_step_time got=+%0d,+%0d required=+4,+13", sq[0] - a, sq[1] - a);
         end
      end
      tests++;
      if (steps_done !== 8'd2 || running !== 1'b0) begin
         fails++;
         $display("FAIL ena_status got sd=%0d run=%b, required sd=2 run=0", steps_done, running);
      end
   endtask
   task automatic test_reset_mid();
      int a;
      send(8'h80, a);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tests++;
      if ({cell_we, step, running, loaded, err, steps_done} !== '0) begin
         fails++;
         $display("FAIL reset_mid_run got run=%b ld=%b err=%b sd=%0d, required all 0", running, loaded, err, steps_done);
      end
      send(8'h43, a);
      send(8'h11, a);
      send(8'h22, a);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_loaded = 0;
      m_err = 0;
      tests++;
      if ({cell_we, step, running, loaded, err, steps_done, cell_addr, cell_wdata} !== '0) begin
         fails++;
         $display("FAIL reset_mid_load got we=%b ld=%b err=%b addr=%0d data=%02h, required all 0",
                  cell_we, loaded, err, cell_addr, cell_wdata);
      end
      ld = '{8'h5A};
      test_load();
   endtask
   task automatic test_random();
      int len;
      for (int it = 0; it < 12; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               ld.delete();
               len = $urandom_range(1, 20);
               repeat (len) ld.push_back(8'($urandom));
               test_load();
            end
            1: test_run($urandom_range(1, 4));
            2: begin
               if (!m_loaded) begin
                  ld.delete();
                  len = $urandom_range(1, NUM);
                  repeat (len) ld.push_back(8'($urandom));
                  test_load();
               end
               test_halt($urandom_range(1, 20), 1'b0);
            end
            default: test_nop();
         endcase
      end
   endtask
   initial begin
      @(negedge clk);
      test_reset();
      test_err_paths();
      ld = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      test_load();
      test_run(3);
      test_halt(12, 1'b1);
      test_nop();
      ld.delete();
      repeat (18) ld.push_back(8'($urandom));
      test_load();
      test_run(2);
      ld = '{8'h01, 8'h02};
      test_load();
      test_ena_freeze();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
